// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// UART boot loader that sits in front of instruction fetch. It receives a
// program image over a serial line and writes it word by word into
// instruction memory. While a load is running, busy_o holds the CPU core in
// reset so the core never fetches a half-written program.
//
// Image format: 16-bit little-endian word count N, then 4*N bytes. Each word
// is little-endian and is written to word addresses 0..N-1.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous, active-high reset
//   start_i      one-cycle pulse that arms a load (ignored while busy)
//   rx_i         UART receive line, idle high, asynchronous to clk_i
//   busy_o       high from the cycle after start until the load ends
//   done_o       one-cycle pulse on successful completion
//   err_o        sticky error flag, cleared by the next accepted start
//   prog_we_o    instruction-memory write strobe, one cycle per word
//   prog_addr_o  word address of the write
//   prog_data_o  word to write
// -----------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_WIDTH   = 14
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  rx_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic                  prog_we_o,
   output logic [ADDR_WIDTH-1:0] prog_addr_o,
   output logic [31:0]           prog_data_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   // Largest legal word count; 17 bits so that 2^16 is representable.
   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_START = 2'd1,
      R_DATA  = 2'd2,
      R_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      L_IDLE  = 3'd0,
      L_LEN0  = 3'd1,
      L_LEN1  = 3'd2,
      L_DATA  = 3'd3,
      L_WRITE = 3'd4,
      L_DONE  = 3'd5
   } ld_state_t;

   // Places one received byte into the given byte lane of a word.
   function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  data);
      logic [31:0] res;
      res = word;
      case (lane)
         2'd0:    res[7:0]   = data;
         2'd1:    res[15:8]  = data;
         2'd2:    res[23:16] = data;
         2'd3:    res[31:24] = data;
         default: res        = word;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------
   // rx conditioning
   // ------------------------------------------------------------------
   logic rx_meta_q;
   logic rx_sync_q;
   logic rx_prev_q;
   logic rx_fall_s;

   // Two-flop synchronizer plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall_s = rx_prev_q & ~rx_sync_q;

   // ------------------------------------------------------------------
   // RX FSM
   // ------------------------------------------------------------------
   rx_state_t        rx_state_q,   rx_state_d;
   logic [CNT_W-1:0] clk_cnt_q,    clk_cnt_d;
   logic [2:0]       bit_cnt_q,    bit_cnt_d;
   logic [7:0]       rx_byte_q,    rx_byte_d;
   logic             byte_valid_q, byte_valid_d;
   logic             frame_err_q,  frame_err_d;

   // RX FSM state and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_state_q   <= R_IDLE;
         clk_cnt_q    <= {CNT_W{1'b0}};
         bit_cnt_q    <= 3'd0;
         rx_byte_q    <= 8'd0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_byte_q    <= rx_byte_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // RX FSM next state: half-bit resample of the start bit, then one sample
   // per bit period so every sample lands near the middle of its bit.
   always_comb begin
      rx_state_d   = rx_state_q;
      clk_cnt_d    = clk_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      rx_byte_d    = rx_byte_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_fall_s) begin
               rx_state_d = R_START;
               clk_cnt_d  = {CNT_W{1'b0}};
            end else begin
               rx_state_d = R_IDLE;
            end
         end
         R_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = {CNT_W{1'b0}};
               bit_cnt_d = 3'd0;
               if (rx_sync_q) begin
                  // Line went back high: a glitch, not a start bit.
                  rx_state_d = R_IDLE;
               end else begin
                  rx_state_d = R_DATA;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = {CNT_W{1'b0}};
               rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = R_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         R_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d  = {CNT_W{1'b0}};
               rx_state_d = R_IDLE;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: begin
            rx_state_d = R_IDLE;
            clk_cnt_d  = {CNT_W{1'b0}};
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------
   ld_state_t             ld_state_q,  ld_state_d;
   logic [15:0]           n_q,         n_d;
   logic [15:0]           word_idx_q,  word_idx_d;
   logic [1:0]            byte_idx_q,  byte_idx_d;
   logic [31:0]           word_buf_q,  word_buf_d;
   logic                  busy_q,      busy_d;
   logic                  done_q,      done_d;
   logic                  err_q,       err_d;
   logic                  prog_we_q,   prog_we_d;
   logic [ADDR_WIDTH-1:0] prog_addr_q, prog_addr_d;
   logic [31:0]           prog_data_q, prog_data_d;
   logic [16:0]           n_full_s;

   // Loader FSM state, counters and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ld_state_q  <= L_IDLE;
         n_q         <= 16'd0;
         word_idx_q  <= 16'd0;
         byte_idx_q  <= 2'd0;
         word_buf_q  <= 32'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         prog_we_q   <= 1'b0;
         prog_addr_q <= {ADDR_WIDTH{1'b0}};
         prog_data_q <= 32'd0;
      end else begin
         ld_state_q  <= ld_state_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         word_buf_q  <= word_buf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         prog_we_q   <= prog_we_d;
         prog_addr_q <= prog_addr_d;
         prog_data_q <= prog_data_d;
      end
   end

   // Loader FSM next state. Outputs are derived from the next state so that
   // they are registered yet line up with the state they describe.
   always_comb begin
      ld_state_d  = ld_state_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      word_buf_d  = word_buf_q;
      err_d       = err_q;
      prog_we_d   = 1'b0;
      prog_addr_d = prog_addr_q;
      prog_data_d = prog_data_q;
      // Full word count as it would be once the high byte is accepted.
      n_full_s    = {1'b0, rx_byte_q, n_q[7:0]};
      case (ld_state_q)
         L_IDLE: begin
            if (start_i) begin
               // start wins over a coincident byte, which is dropped.
               ld_state_d = L_LEN0;
               err_d      = 1'b0;
               word_idx_d = 16'd0;
               byte_idx_d = 2'd0;
            end else if (frame_err_q) begin
               err_d = 1'b1;
            end else begin
               ld_state_d = L_IDLE;
            end
         end
         L_LEN0: begin
            if (frame_err_q) begin
               err_d      = 1'b1;
               ld_state_d = L_IDLE;
            end else if (byte_valid_q) begin
               n_d[7:0]   = rx_byte_q;
               ld_state_d = L_LEN1;
            end else begin
               ld_state_d = L_LEN0;
            end
         end
         L_LEN1: begin
            if (frame_err_q) begin
               err_d      = 1'b1;
               ld_state_d = L_IDLE;
            end else if (byte_valid_q) begin
               n_d = n_full_s[15:0];
               if (n_full_s == 17'd0) begin
                  ld_state_d = L_DONE;
               end else if (n_full_s > MAX_WORDS) begin
                  err_d      = 1'b1;
                  ld_state_d = L_IDLE;
               end else begin
                  ld_state_d = L_DATA;
               end
            end else begin
               ld_state_d = L_LEN1;
            end
         end
         L_DATA: begin
            if (frame_err_q) begin
               err_d      = 1'b1;
               ld_state_d = L_IDLE;
            end else if (byte_valid_q) begin
               word_buf_d = insert_lane(word_buf_q, byte_idx_q, rx_byte_q);
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  // Word complete: the write strobe appears next cycle.
                  ld_state_d  = L_WRITE;
                  prog_we_d   = 1'b1;
                  prog_addr_d = word_idx_q[ADDR_WIDTH-1:0];
                  prog_data_d = word_buf_d;
               end else begin
                  ld_state_d = L_DATA;
               end
            end else begin
               ld_state_d = L_DATA;
            end
         end
         L_WRITE: begin
            word_idx_d = word_idx_q + 16'd1;
            if (frame_err_q) begin
               err_d      = 1'b1;
               ld_state_d = L_IDLE;
            end else if (word_idx_d == n_q) begin
               ld_state_d = L_DONE;
            end else begin
               ld_state_d = L_DATA;
            end
         end
         L_DONE: begin
            ld_state_d = L_IDLE;
            if (frame_err_q) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         default: begin
            ld_state_d = L_IDLE;
         end
      endcase
      busy_d = (ld_state_d != L_IDLE);
      done_d = (ld_state_d == L_DONE);
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign prog_we_o   = prog_we_q;
   assign prog_addr_o = prog_addr_q;
   assign prog_data_o = prog_data_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_loader
//
// Self-checking bench for uart_prog_loader with CLKS_PER_BIT=4, ADDR_WIDTH=4.
// A table of directed images plus randomised images are sent over rx; a
// reference model parses the byte stream by the image-format rules and
// predicts writes, done and err.
// -----------------------------------------------------------------------------
module tb_uart_prog_loader;

   localparam int CPB  = 4;
   localparam int AW   = 4;
   localparam int MAXW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          rx;
   logic          busy;
   logic          done;
   logic          err;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;

   uart_prog_loader #(
      .CLKS_PER_BIT(CPB),
      .ADDR_WIDTH  (AW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .rx_i       (rx),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .prog_we_o  (prog_we),
      .prog_addr_o(prog_addr),
      .prog_data_o(prog_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // ---------------- output monitor ----------------
   logic [AW-1:0] wq_addr[$];
   logic [31:0]   wq_data[$];
   int            done_cnt    = 0;
   int            cyc         = 0;
   int            last_we_cyc = 0;
   int            done_cyc    = 0;
   int            viol        = 0;
   logic          prev_done   = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_done <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (prog_we) begin
            wq_addr.push_back(prog_addr);
            wq_data.push_back(prog_data);
            last_we_cyc <= cyc;
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (prev_done && busy) viol <= viol + 1;
         prev_done <= done;
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]    tx_q[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_data[$];
   int            m_done;
   int            m_err;
   int            w0, d0, v0;

   task automatic model_expect(input int bad_idx);
      int good;
      int n;
      exp_addr.delete();
      exp_data.delete();
      good   = (bad_idx < 0) ? tx_q.size() : bad_idx;
      m_err  = (bad_idx >= 0) ? 1 : 0;
      m_done = 0;
      if (good >= 2) begin
         n = int'(tx_q[0]) + 256 * int'(tx_q[1]);
         if (n > MAXW) begin
            m_err = 1;
         end else begin
            for (int i = 0; i < n; i++) begin
               if (2 + 4 * i + 3 < good) begin
                  exp_addr.push_back(AW'(i));
                  exp_data.push_back({tx_q[5+4*i], tx_q[4+4*i], tx_q[3+4*i], tx_q[2+4*i]});
               end
            end
            if (bad_idx < 0 && good >= 2 + 4 * n) m_done = 1;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic snap();
      w0 = wq_addr.size();
      d0 = done_cnt;
      v0 = viol;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok ? 1'b1 : 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_range(input int lo, input int hi, input int bad_idx);
      for (int i = lo; i < hi; i++) send_byte(tx_q[i], i != bad_idx);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && busy; i++) @(negedge clk);
      chk("busy_release", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic finish_check(input int exp_n, input int exp_d, input int exp_e);
      int got;
      got = wq_addr.size() - w0;
      chk("write_count", 32'(got), 32'(exp_n));
      for (int i = 0; i < exp_addr.size() && i < got; i++) begin
         chk("write_addr", 32'(wq_addr[w0+i]), 32'(exp_addr[i]));
         chk("write_data", wq_data[w0+i], exp_data[i]);
      end
      chk("done_count", 32'(done_cnt - d0), 32'(exp_d));
      chk("err_flag", 32'(err), 32'(exp_e));
      chk("busy_low_end", 32'(busy), 32'd0);
      chk("busy_after_done", 32'(viol - v0), 32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      int          nbytes;
      logic [95:0] bytes;   // first byte leftmost, right-aligned
      int          bad;     // index of byte sent with stop bit 0, -1 for none
      int          exp_w;
      int          exp_d;
      int          exp_e;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input int nb, input logic [95:0] by, input int bad,
                               input int w, input int d, input int e);
      vec_t v;
      v.nbytes = nb;
      v.bytes  = by;
      v.bad    = bad;
      v.exp_w  = w;
      v.exp_d  = d;
      v.exp_e  = e;
      return v;
   endfunction

   initial begin
      int n;
      vec_t v;

      vecs[0] = mk(10, 96'h02_00_13_05_A0_00_93_05_10_00, -1, 2, 1, 0);
      vecs[1] = mk(2,  96'h00_00,                          -1, 0, 1, 0);
      vecs[2] = mk(3,  96'h01_00_11,                        2, 0, 0, 1);
      vecs[3] = mk(2,  96'h11_00,                          -1, 0, 0, 1);
      vecs[4] = mk(6,  96'h01_00_EF_BE_AD_DE,              -1, 1, 1, 0);
      vecs[5] = mk(2,  96'h00_01,                          -1, 0, 0, 1);

      // ---- reset ----
      rst   = 1'b1;
      start = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_we", 32'(prog_we), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_we", 32'(prog_we), 32'd0);

      // ---- table-driven loads ----
      for (int t = 0; t < 6; t++) begin
         v = vecs[t];
         tx_q.delete();
         for (int i = 0; i < v.nbytes; i++) tx_q.push_back(v.bytes[(v.nbytes-1-i)*8 +: 8]);
         model_expect(v.bad);
         snap();
         pulse_start();
         send_range(0, v.nbytes, v.bad);
         wait_idle();
         finish_check(v.exp_w, v.exp_d, v.exp_e);
         if (v.exp_w > 0 && v.exp_d == 1)
            chk("done_after_last_write", 32'(done_cyc), 32'(last_we_cyc + 1));
      end

      // ---- start after an error clears err ----
      tx_q.delete();
      tx_q.push_back(8'h00);
      tx_q.push_back(8'h00);
      model_expect(-1);
      snap();
      pulse_start();
      chk("err_cleared_by_start", 32'(err), 32'd0);
      send_range(0, 2, -1);
      wait_idle();
      finish_check(0, 1, 0);

      // ---- one-cycle rx glitch while idle ----
      snap();
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_writes", 32'(wq_addr.size() - w0), 32'd0);
      chk("glitch_done", 32'(done_cnt - d0), 32'd0);
      chk("glitch_err", 32'(err), 32'd0);
      chk("glitch_busy", 32'(busy), 32'd0);

      // ---- start while busy is ignored ----
      tx_q.delete();
      tx_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      model_expect(-1);
      snap();
      pulse_start();
      send_range(0, 2, -1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_range(2, 6, -1);
      wait_idle();
      finish_check(1, 1, 0);

      // ---- randomised images, first one at the maximum word count ----
      for (int it = 0; it < 4; it++) begin
         n = (it == 0) ? MAXW : int'($urandom_range(1, MAXW));
         tx_q.delete();
         tx_q.push_back(8'(n));
         tx_q.push_back(8'(n >> 8));
         for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
         model_expect(-1);
         snap();
         pulse_start();
         send_range(0, tx_q.size(), -1);
         wait_idle();
         finish_check(exp_addr.size(), m_done, m_err);
      end

      // ---- reset in the middle of a load ----
      tx_q.delete();
      tx_q = {8'h02, 8'h00};
      snap();
      pulse_start();
      send_range(0, 2, -1);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_we", 32'(prog_we), 32'd0);
      rx = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("after_abort_busy", 32'(busy), 32'd0);
      chk("after_abort_err", 32'(err), 32'd0);
      chk("after_abort_writes", 32'(wq_addr.size() - w0), 32'd0);
      chk("after_abort_done", 32'(done_cnt - d0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART boot loader upstream of instruction fetch: receives a program over a serial line and writes it word-by-word into instruction memory.
- While loading, `busy` holds the CPU core in reset, so the core never fetches a half-written program.
- Frame format: 16-bit little-endian word count N, then 4*N bytes. Each word is little-endian and written to word address 0..N-1.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_WIDTH, 14, instruction-memory word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a load; ignored while busy.
- rx  in  1  UART receive line, idle high, asynchronous to clk.
- busy  out  1  high from the cycle after start until the load ends; the core's reset is ORed with this.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared by the next accepted start.
- prog_we  out  1  instruction-memory write strobe, one cycle per word.
- prog_addr  out  ADDR_WIDTH  word address of the write.
- prog_data  out  32  word to write.

Behaviour:
- Reset: all outputs 0; both FSMs idle; counters 0. Reset mid-load aborts immediately; memory already written is left as is.
- rx input conditioning:
  - rx passes through a 2-flop synchronizer.
  - 2-cycle latency from a pin change to the internal signal.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE -> R_START on a synchronized falling edge.
  - R_START: wait CLKS_PER_BIT/2 cycles and resample. If high (glitch), return to R_IDLE; else go to R_DATA.
  - R_DATA: sample 8 bits LSB first, one every CLKS_PER_BIT cycles.
  - R_STOP: sample the stop bit after CLKS_PER_BIT cycles.
    - Stop bit 1: assert an internal byte_valid for one cycle, then go to R_IDLE.
    - Stop bit 0: framing error; byte discarded, go to R_IDLE.
  - The RX FSM runs regardless of busy. Bytes received while the loader is in L_IDLE are dropped.
- Loader FSM states: L_IDLE, L_LEN0, L_LEN1, L_DATA, L_WRITE, L_DONE.
  - L_IDLE: on start, clear err, word index and byte index; go to L_LEN0; busy=1 from the next cycle.
  - L_LEN0: byte_valid -> N[7:0]; go to L_LEN1.
  - L_LEN1: byte_valid -> N[15:8].
    - N == 0: go to L_DONE.
    - N > 2^ADDR_WIDTH: set err, go to L_IDLE.
    - Otherwise: go to L_DATA.
  - L_DATA: each byte_valid shifts into the word buffer at lane byte_idx (byte 0 = bits 7:0). byte_idx increments mod 4. The 4th byte moves the FSM to L_WRITE.
  - L_WRITE (exactly one cycle): prog_we=1, prog_addr=word_idx, prog_data=assembled word; word_idx++.
    - If the new word_idx == N, go to L_DONE; else go to L_DATA.
    - prog_we fires on the cycle after the 4th byte_valid.
  - L_DONE (one cycle): done=1; busy drops the following cycle; go to L_IDLE.
- Framing error while busy: err=1; load aborted to L_IDLE; busy drops next cycle; no done pulse. A framing error outside a load also sets err.
- A start that coincides with a byte_valid while in L_IDLE: start wins; that byte is dropped.
- prog_addr and prog_data hold their last values when prog_we=0.
- Address wrap is impossible because N is bounded; word_idx is 16 bits wide internally.

Test Plan (CLKS_PER_BIT=4, ADDR_WIDTH=4):
1. Reset held, then released -> busy=done=err=prog_we=0. Assert rst mid-load -> busy=0 asynchronously.
2. start, send bytes 02 00 13 05 A0 00 93 05 10 00:
   - prog_we pulses twice: addr 0 data 0x00A00513, addr 1 data 0x00100593.
   - done pulses once, one cycle after the second write; busy low the cycle after done.
3. start, send 00 00 -> no prog_we; done pulses; err=0.
4. start, send 01 00 then byte 0x11 with stop bit 0 -> err=1; busy falls; no done; no prog_we. A following start clears err.
5. rx low glitch of 1 cycle in idle -> no byte_valid; FSMs unchanged. start during busy -> ignored, load completes normally.
6. start, send 11 00 (N=17 > 16) -> err=1; busy falls; no writes.
